fifo_wr_ctrl: RTL
=================

# fifo_wr_ctrl

Write-domain control for the dual-clock Ethernet FIFO. The block owns the write pointer and drives the memory write strobe and address. It synchronizes the Gray-coded read pointer from the read domain and produces registered full, almost-full, fill-level and sticky-overflow status. It sits beside the FIFO memory and pairs with the read-side pointer block across the clock boundary.

## Interface
- ADDR_WIDTH, 4, memory address width; FIFO depth DEPTH = 2^ADDR_WIDTH
- AF_LEVEL, 12, almost_full asserts when fill level >= AF_LEVEL; legal range 1..DEPTH
- SYNC_STAGES, 2, flops in the rd_ptr synchronizer chain; minimum 2

- clk  in  1  write-domain clock
- reset_n  in  1  synchronous, active-low reset
- write  in  1  write request from upstream
- clr_overflow  in  1  clears the sticky overflow flag
- rd_ptr_async  in  ADDR_WIDTH+1  Gray-coded read pointer from read domain, unsynchronized
- wr_en  out  1  memory write strobe, combinational: write & !full
- wr_addr  out  ADDR_WIDTH  memory write address, binary, low bits of write pointer
- wr_ptr  out  ADDR_WIDTH+1  registered Gray-coded write pointer, to read domain
- full  out  1  registered full flag
- almost_full  out  1  registered, level >= AF_LEVEL
- wr_level  out  ADDR_WIDTH+1  registered fill level as seen from the write domain, 0..DEPTH
- overflow  out  1  sticky; set by write while full

## Operation
- Binary pointer bin, ADDR_WIDTH+1 bits. bnext = bin + (write & !full). gnext = (bnext >> 1) ^ bnext.
- Synchronizer: rd_ptr_async shifts through SYNC_STAGES flops. The last stage rd_sync is the only value used. No combinational logic is allowed before the first flop.
- rd_bin = Gray-to-binary of rd_sync: MSB passes through; each lower bit is the XOR of itself with the next higher binary bit.
- full_next = (gnext == {~rd_sync[ADDR_WIDTH:ADDR_WIDTH-1], rd_sync[ADDR_WIDTH-2:0]}).
- level_next = bnext - rd_bin, modulo 2^(ADDR_WIDTH+1). The result always lies in 0..DEPTH.
- almost_full_next = (level_next >= AF_LEVEL).
- Each clk edge registers bin <= bnext, wr_ptr <= gnext, full <= full_next, wr_level <= level_next and almost_full <= almost_full_next.
- Overflow: write & full sets overflow. The write is dropped; pointers, wr_en and memory are unaffected. clr_overflow clears overflow. If a set and a clear occur in the same cycle, the set wins.
- Reset: bin, wr_ptr, wr_level and all synchronizer flops go to 0. full, almost_full and overflow go to 0. wr_addr is 0 and wr_en is 0 while full=0 and write=0. Reset asserted mid-operation discards all state on that edge. The read domain must also be reset; no cross-domain reset handshake exists in this block.
- Pointer wrap: bin rolls over from 2^(ADDR_WIDTH+1)-1 to 0 with no special handling. The Gray MSB pair distinguishes full from empty.

## Timing
- Write acceptance: the word is written at wr_addr in the cycle where wr_en=1. wr_addr, wr_ptr and wr_level update on the following edge.
- full asserts on the same edge that accepts the DEPTH-th unread word. No write is lost at the boundary.
- Read-side release latency: if rd_ptr_async changes and is stable at edge N, rd_sync updates at edge N+SYNC_STAGES-1. full, wr_level and almost_full reflect the change after edge N+SYNC_STAGES. With the default, that is 2 edges after capture.
- Status is conservative: full and wr_level may lag reads, never writes.
- wr_ptr changes by exactly one Gray bit per accepted write.

## Test plan
- Reset: hold reset_n=0 for 3 cycles with write=1 -> all outputs 0, wr_en=0; wr_addr stays 0 on release with write=0.
- Fill: ADDR_WIDTH=4, rd_ptr_async=0, 16 back-to-back writes -> wr_level counts 1..16; almost_full rises after write 12; full rises on the edge accepting write 16; wr_ptr=5'b11000.
- Overflow: from full, write=1 for 2 cycles -> wr_en=0, wr_ptr and wr_addr unchanged, overflow=1. Pulse clr_overflow alone -> overflow=0. Pulse clr_overflow together with write while full -> overflow stays 1.
- Release: from full, set rd_ptr_async=5'b00001 -> full=0 and wr_level=15 exactly 2 edges later, not earlier. The next write is accepted at wr_addr=0.
- Wrap: 40 writes, with the bench advancing rd_ptr_async (Gray) 3 cycles behind each write -> wr_addr wraps 15->0, bin wraps 31->0, wr_ptr returns to 0 after 32 writes with a single-bit change each step, full never asserts, wr_level stays <= 4.
- Mid-run reset: assert reset_n=0 at level 9 with overflow=1 -> next edge gives all outputs 0; the subsequent write lands at wr_addr=0.

Source files
------------

// File: rtl/fifo_wr_ctrl_if.sv
// Write-side bundle of the dual-clock Ethernet FIFO: upstream request, read-pointer
// crossing input, memory strobe/address and write-domain status.
interface fifo_wr_ctrl_if #(
    parameter int ADDR_WIDTH = 4
);
    logic                  write;
    logic                  clr_overflow;
    logic [ADDR_WIDTH:0]   rd_ptr_async;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [ADDR_WIDTH:0]   wr_ptr;
    logic                  full;
    logic                  almost_full;
    logic [ADDR_WIDTH:0]   wr_level;
    logic                  overflow;

    // Upstream writer / environment side.
    modport master (
        output write,
        output clr_overflow,
        output rd_ptr_async,
        input  wr_en,
        input  wr_addr,
        input  wr_ptr,
        input  full,
        input  almost_full,
        input  wr_level,
        input  overflow
    );

    // Write-pointer controller side.
    modport slave (
        input  write,
        input  clr_overflow,
        input  rd_ptr_async,
        output wr_en,
        output wr_addr,
        output wr_ptr,
        output full,
        output almost_full,
        output wr_level,
        output overflow
    );
endinterface

// File: rtl/fifo_wr_ctrl.sv
// Write-domain pointer/status controller: owns the write pointer, synchronizes the
// Gray read pointer and registers full, almost_full, fill level and sticky overflow.
module fifo_wr_ctrl #(
    parameter int ADDR_WIDTH  = 4,
    parameter int AF_LEVEL    = 12,
    parameter int SYNC_STAGES = 2
) (
    input  logic          clk,
    input  logic          reset_n,
    fifo_wr_ctrl_if.slave bus
);
    localparam int PW = ADDR_WIDTH + 1;
    localparam logic [ADDR_WIDTH:0] AF_THRESH = PW'(AF_LEVEL);

    logic [ADDR_WIDTH:0] bin;
    logic [ADDR_WIDTH:0] bnext;
    logic [ADDR_WIDTH:0] gnext;
    logic [ADDR_WIDTH:0] wr_ptr_q;
    logic [ADDR_WIDTH:0] wr_level_q;
    logic [ADDR_WIDTH:0] level_next;
    logic [ADDR_WIDTH:0] rd_sync;
    logic [ADDR_WIDTH:0] rd_bin;
    logic [ADDR_WIDTH:0] sync_q [SYNC_STAGES];
    logic                accept;
    logic                full_q;
    logic                full_next;
    logic                almost_full_q;
    logic                overflow_q;

    // NOTE: the synchronizer is a bank of individual flops, so every stage is
    // cleared on reset; a stale pointer surviving reset would fake a fill level.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= bus.rd_ptr_async;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign rd_sync = sync_q[SYNC_STAGES-1];

    // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
    for (genvar i = 0; i <= ADDR_WIDTH; i++) begin : g_rd_bin
        assign rd_bin[i] = ^rd_sync[ADDR_WIDTH:i];
    end

    assign accept     = bus.write & ~full_q;
    assign bnext      = bin + {{ADDR_WIDTH{1'b0}}, accept};
    assign gnext      = (bnext >> 1) ^ bnext;
    assign full_next  = (gnext == {~rd_sync[ADDR_WIDTH:ADDR_WIDTH-1], rd_sync[ADDR_WIDTH-2:0]});
    assign level_next = bnext - rd_bin;

    // NOTE: all state uses non-blocking assignments so every register samples
    // pre-edge values and simulation order cannot change behaviour.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            bin           <= '0;
            wr_ptr_q      <= '0;
            wr_level_q    <= '0;
            full_q        <= 1'b0;
            almost_full_q <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            bin           <= bnext;
            wr_ptr_q      <= gnext;
            wr_level_q    <= level_next;
            full_q        <= full_next;
            almost_full_q <= (level_next >= AF_THRESH);
            if (bus.write && full_q) begin
                overflow_q <= 1'b1;
            end else if (bus.clr_overflow) begin
                overflow_q <= 1'b0;
            end
        end
    end

    // The strobe is held off while reset is asserted so the memory is never
    // written with a request that the pointer logic is about to discard.
    assign bus.wr_en       = accept & reset_n;
    assign bus.wr_addr     = bin[ADDR_WIDTH-1:0];
    assign bus.wr_ptr      = wr_ptr_q;
    assign bus.wr_level    = wr_level_q;
    assign bus.full        = full_q;
    assign bus.almost_full = almost_full_q;
    assign bus.overflow    = overflow_q;
endmodule
